alu_result_checker: RTL

//   Synthesizable self-check monitor for the 8-bit ALU result interface. It

---
 rtl/alu_result_checker_if.sv | 13 +
 rtl/alu_result_checker.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_result_checker_if.sv
// Transaction and observed-result bus between the ALU stimulus source and
// alu_result_checker.
interface alu_result_checker_if;
  logic       in_valid;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] dut_result;
  logic       dut_carry;

  modport master (output in_valid, op, a, b, dut_result, dut_carry);
  modport slave  (input  in_valid, op, a, b, dut_result, dut_carry);
endinterface

// File: rtl/alu_result_checker.sv
// On-chip scoreboard for the 8-bit ALU: predicts each result, compares it
// LATENCY cycles later, and keeps saturating counts plus a first-failure capture.
module alu_result_checker #(
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 16,
  parameter int CHECK_CARRY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_checker_if.slave  bus,
  input  logic                 clear,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [1:0]           status,
  output logic [2:0]           fail_op,
  output logic [7:0]           fail_exp,
  output logic [7:0]           fail_got
);

  localparam int LAST = LATENCY - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PASSING = 2'b01,
    FAILED  = 2'b10
  } state_t;

  // Returns {carry, result}; carry is only meaningful for ADD and SUB.
  function automatic logic [8:0] golden(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] r;
    r = 9'd0;
    case (op)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {(a < b), a - b};
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, ~a};
      3'b101:  r = {1'b0, a << b[2:0]};
      3'b110:  r = {1'b0, a >> b[2:0]};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [LATENCY-1:0] vld_p;
  logic [7:0]         exp_p       [LATENCY];
  logic               exp_carry_p [LATENCY];
  logic [2:0]         op_p        [LATENCY];
  logic               chk_p       [LATENCY];

  logic   cmp_due;
  logic   match;
  logic   load_fail;
  state_t state;
  state_t state_nxt;

  // Stage 0..LAST: record pipeline; only the valid bits carry reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (clear) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= bus.in_valid;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      {exp_carry_p[0], exp_p[0]} <= golden(bus.op, bus.a, bus.b);
      op_p[0]  <= bus.op;
      chk_p[0] <= (CHECK_CARRY != 0) && ((bus.op == OP_ADD) || (bus.op == OP_SUB));
    end
    for (int i = 1; i < LATENCY; i++) begin
      exp_p[i]       <= exp_p[i-1];
      exp_carry_p[i] <= exp_carry_p[i-1];
      op_p[i]        <= op_p[i-1];
      chk_p[i]       <= chk_p[i-1];
    end
  end

  // Compare stage: final record against the live ALU outputs
  assign cmp_due = vld_p[LAST] && !clear;
  assign match   = (bus.dut_result == exp_p[LAST]) &&
                   (!chk_p[LAST] || (bus.dut_carry == exp_carry_p[LAST]));

  always_comb begin
    state_nxt = state;
    load_fail = 1'b0;
    if (cmp_due) begin
      case (state)
        IDLE: begin
          state_nxt = match ? PASSING : FAILED;
          load_fail = !match;
        end
        PASSING: begin
          if (!match) begin
            state_nxt = FAILED;
            load_fail = 1'b1;
          end
        end
        FAILED:  state_nxt = FAILED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  // Result stage: registered counters and first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      fail_op  <= '0;
      fail_exp <= '0;
      fail_got <= '0;
    end else if (clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      fail_op  <= '0;
      fail_exp <= '0;
      fail_got <= '0;
    end else if (cmp_due) begin
      if (match) pass_cnt <= sat_inc(pass_cnt);
      else       fail_cnt <= sat_inc(fail_cnt);
      if (load_fail) begin
        fail_op  <= op_p[LAST];
        fail_exp <= exp_p[LAST];
        fail_got <= bus.dut_result;
      end
    end
  end

  assign status = state;

endmodule
